// File: rtl/mem_line_arbiter.sv
// Two-requester round-robin arbiter moving whole cache lines to/from a single-port memory.
// Reads pipeline one address ahead because the memory returns data one cycle after mem_addr.
module mem_line_arbiter #(
    parameter int ADDR_LEN = 11,
    parameter int LINE_LEN = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [2*ADDR_LEN-1:0] addr,
    input  logic [63:0]           wdata,
    output logic [1:0]            beat,
    output logic [31:0]           rdata,
    output logic [1:0]            done,
    output logic [ADDR_LEN-1:0]   mem_addr,
    output logic                  mem_wr_req,
    output logic [31:0]           mem_wr_data,
    input  logic [31:0]           mem_rd_data
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRead  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [LINE_LEN:0]   LastWrite = (LINE_LEN + 1)'((1 << LINE_LEN) - 1);
    localparam logic [LINE_LEN:0]   LastRead  = (LINE_LEN + 1)'(1 << LINE_LEN);
    localparam logic [ADDR_LEN-1:0] LineMask  = ADDR_LEN'((1 << LINE_LEN) - 1);

    logic [1:0]          state_q, state_d;
    logic [LINE_LEN:0]   cnt_q, cnt_d;
    logic [ADDR_LEN-1:0] base_q, base_d;
    logic                gnt_q, gnt_d;
    logic                prio_q, prio_d;

    logic                pick;
    logic [ADDR_LEN-1:0] pick_addr;
    logic [ADDR_LEN-1:0] word_addr;
    logic [1:0]          gnt_oh;

    // Contention goes to the pointer; a lone requester wins outright.
    assign pick      = (req == 2'b11) ? prio_q : req[1];
    assign pick_addr = pick ? addr[2*ADDR_LEN-1:ADDR_LEN] : addr[ADDR_LEN-1:0];
    // Offset is OR-ed into the aligned base, so it can never carry into the line address.
    assign word_addr = base_q | ADDR_LEN'(cnt_q[LINE_LEN-1:0]);
    assign gnt_oh    = {gnt_q, ~gnt_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        gnt_d   = gnt_q;
        prio_d  = prio_q;
        case (state_q)
            StIdle: begin
                if (req != 2'b00) begin
                    gnt_d   = pick;
                    base_d  = pick_addr & ~LineMask;
                    cnt_d   = '0;
                    state_d = we[pick] ? StWrite : StRead;
                end
            end
            StWrite: begin
                cnt_d = cnt_q + (LINE_LEN + 1)'(1);
                if (cnt_q == LastWrite) begin
                    state_d = StDone;
                end
            end
            StRead: begin
                cnt_d = cnt_q + (LINE_LEN + 1)'(1);
                if (cnt_q == LastRead) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                prio_d  = ~prio_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        beat        = '0;
        rdata       = '0;
        done        = '0;
        mem_addr    = '0;
        mem_wr_req  = 1'b0;
        mem_wr_data = '0;
        case (state_q)
            StWrite: begin
                mem_addr    = word_addr;
                mem_wr_req  = 1'b1;
                mem_wr_data = gnt_q ? wdata[63:32] : wdata[31:0];
                beat        = gnt_oh;
            end
            StRead: begin
                if (cnt_q < LastRead) begin
                    mem_addr = word_addr;
                end
                // Data for word cnt-1 arrives this cycle.
                if (cnt_q != '0) begin
                    beat  = gnt_oh;
                    rdata = mem_rd_data;
                end
            end
            StDone:  done = gnt_oh;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            base_q  <= '0;
            gnt_q   <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
        end
    end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Self-checking bench for mem_line_arbiter: directed table, hand sequences and random traffic
// checked cycle by cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_line_arbiter;
    localparam int AW = 11;
    localparam int N  = 8;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0][31:0] data;
    } job_t;

    typedef struct packed {
        logic          rq;
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [7:0]    dbase;
        logic [7:0]    fb;
        logic [7:0]    dc;
        logic [AW-1:0] a_first;
        logic [AW-1:0] a_last;
        logic [31:0]   w0;
        logic [31:0]   w7;
    } vec_t;

    logic          clk, rst;
    logic [1:0]    req, we;
    logic [2*AW-1:0] addr;
    logic [63:0]   wdata;
    logic [1:0]    beat, done;
    logic [31:0]   rdata, mem_wr_data, mem_rd_data;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_req;

    mem_line_arbiter #(.ADDR_LEN(AW), .LINE_LEN(3)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .beat(beat), .rdata(rdata), .done(done), .mem_addr(mem_addr),
        .mem_wr_req(mem_wr_req), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks, errors, cyc, wr_count;
    logic [31:0] mem [0:2047];
    logic [31:0] ref_mem [0:2047];
    job_t jq0[$], jq1[$];
    int bc[2];

    // Reference model: which transfer is in flight and how many cycles since its grant.
    bit m_busy, m_g, m_we, m_prio;
    int m_k;
    logic [AW-1:0] m_base;
    logic [7:0][31:0] m_data;

    logic [1:0]  beat_hist[$], done_hist[$];
    logic [AW-1:0] maddr_hist[$];
    logic [31:0] rdata_hist[$];
    int done_log[$], done_cyc_log[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic preload();
        logic [31:0] init [8];
        init = '{32'h61, 32'hE6, 32'h60, 32'h54, 32'h72, 32'hE2, 32'hC3, 32'h46};
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        for (int i = 0; i < 8; i++) mem[i] = init[i];
        mem[19] = 32'hA2;
        for (int i = 0; i < 2048; i++) ref_mem[i] = mem[i];
    endtask

    task automatic drive();
        job_t j;
        req = '0; we = '0; addr = '0; wdata = '0;
        if (jq0.size() > 0) begin
            j = jq0[0];
            req[0] = 1'b1; we[0] = j.we; addr[AW-1:0] = j.addr;
            if (bc[0] < N) wdata[31:0] = j.data[bc[0]];
        end
        if (jq1.size() > 0) begin
            j = jq1[0];
            req[1] = 1'b1; we[1] = j.we; addr[2*AW-1:AW] = j.addr;
            if (bc[1] < N) wdata[63:32] = j.data[bc[1]];
        end
    endtask

    task automatic push_job(int i, logic w, logic [AW-1:0] a, logic [7:0] dbase, bit rnd);
        job_t j;
        j.we = w; j.addr = a;
        for (int k = 0; k < N; k++) j.data[k] = rnd ? $urandom : 32'(dbase) + 32'(k);
        if (i == 0) jq0.push_back(j); else jq1.push_back(j);
    endtask

    task automatic clear_state();
        jq0.delete(); jq1.delete();
        bc[0] = 0; bc[1] = 0;
        m_busy = 0; m_prio = 0; m_k = 0;
        drive();
    endtask

    // One clock: check outputs at the falling edge, clock the memory, then update requesters.
    task automatic step();
        logic [1:0] e_beat, e_done, s_beat, s_done;
        logic [AW-1:0] e_addr, c_addr;
        logic e_wr, c_wr;
        logic [31:0] e_wd, e_rd, c_wd;
        int len, g;
        @(negedge clk);
        e_beat = '0; e_done = '0; e_addr = '0; e_wr = 0; e_wd = '0; e_rd = '0;
        len = m_we ? N : N + 1;
        if (!rst && m_busy) begin
            if (m_k < len) begin
                if (m_we) begin
                    e_addr = m_base + AW'(m_k); e_wr = 1; e_wd = m_data[m_k];
                    e_beat = m_g ? 2'b10 : 2'b01;
                end else begin
                    if (m_k < N) e_addr = m_base + AW'(m_k);
                    if (m_k >= 1) begin
                        e_beat = m_g ? 2'b10 : 2'b01;
                        e_rd = ref_mem[m_base + AW'(m_k - 1)];
                    end
                end
            end else begin
                e_done = m_g ? 2'b10 : 2'b01;
            end
        end
        chk("beat", 64'(beat), 64'(e_beat));
        chk("done", 64'(done), 64'(e_done));
        chk("mem_addr", 64'(mem_addr), 64'(e_addr));
        chk("mem_wr", 64'({mem_wr_req, mem_wr_data}), 64'({e_wr, e_wd}));
        chk("rdata", 64'(rdata), 64'(e_rd));
        if (!rst) begin
            if (m_busy) begin
                if (m_we && m_k < N) ref_mem[m_base + AW'(m_k)] = m_data[m_k];
                if (m_k == len) begin m_busy = 0; m_prio = !m_prio; end
                m_k++;
            end else if (req != 2'b00) begin
                g = (req == 2'b11) ? (m_prio ? 1 : 0) : (req[1] ? 1 : 0);
                m_busy = 1; m_g = (g == 1); m_k = 0; m_we = we[g];
                m_base = addr[g*AW +: AW] & ~AW'(N - 1);
                m_data = (g == 0) ? jq0[0].data : jq1[0].data;
            end
        end
        beat_hist.push_back(beat); done_hist.push_back(done);
        maddr_hist.push_back(mem_addr); rdata_hist.push_back(rdata);
        if (mem_wr_req) wr_count++;
        for (int i = 0; i < 2; i++)
            if (done[i]) begin done_log.push_back(i); done_cyc_log.push_back(cyc); end
        s_beat = beat; s_done = done;
        c_wr = mem_wr_req; c_addr = mem_addr; c_wd = mem_wr_data;
        @(posedge clk);
        mem_rd_data = mem[c_addr];
        if (c_wr) mem[c_addr] = c_wd;
        cyc++;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (s_done[i]) begin
                if (i == 0 && jq0.size() > 0) void'(jq0.pop_front());
                if (i == 1 && jq1.size() > 0) void'(jq1.pop_front());
                bc[i] = 0;
            end else if (s_beat[i]) begin
                bc[i]++;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_state();
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        beat_hist.delete(); done_hist.delete(); maddr_hist.delete(); rdata_hist.delete();
        done_log.delete(); done_cyc_log.delete(); wr_count = 0;
    endtask

    vec_t tbl[5];
    int fb, dc, n;

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; mem_rd_data = '0;
        checks = 0; errors = 0; cyc = 0; wr_count = 0;
        m_g = 0; m_we = 0; m_base = '0; m_data = '0;
        tbl[0] = '{rq:1'b0, is_wr:1'b0, addr:11'h005, dbase:8'h00, fb:8'd2, dc:8'd10,
                   a_first:11'h000, a_last:11'h007, w0:32'h61, w7:32'h46};
        tbl[1] = '{rq:1'b1, is_wr:1'b1, addr:11'h010, dbase:8'hA0, fb:8'd1, dc:8'd9,
                   a_first:11'h010, a_last:11'h017, w0:32'hA0, w7:32'hA7};
        tbl[2] = '{rq:1'b1, is_wr:1'b0, addr:11'h010, dbase:8'h00, fb:8'd2, dc:8'd10,
                   a_first:11'h010, a_last:11'h017, w0:32'hA0, w7:32'hA7};
        tbl[3] = '{rq:1'b0, is_wr:1'b1, addr:11'h7FF, dbase:8'hC0, fb:8'd1, dc:8'd9,
                   a_first:11'h7F8, a_last:11'h7FF, w0:32'hC0, w7:32'hC7};
        tbl[4] = '{rq:1'b0, is_wr:1'b0, addr:11'h7FB, dbase:8'h00, fb:8'd2, dc:8'd10,
                   a_first:11'h7F8, a_last:11'h7FF, w0:32'hC0, w7:32'hC7};
        preload();
        do_reset();

        // Isolated transfers: latency, address walk and data.
        for (int t = 0; t < 5; t++) begin
            clear_logs();
            push_job(int'(tbl[t].rq), tbl[t].is_wr, tbl[t].addr, tbl[t].dbase, 0);
            drive();
            n = 0;
            while (done_log.size() == 0 && n < 40) begin step(); n++; end
            fb = -1; dc = -1;
            for (int i = beat_hist.size() - 1; i >= 0; i--) if (beat_hist[i] != 0) fb = i;
            for (int i = 0; i < done_hist.size(); i++) if (done_hist[i] != 0) dc = i;
            chk("first_beat", 64'(fb), 64'(tbl[t].fb));
            chk("done_cycle", 64'(dc), 64'(tbl[t].dc));
            chk("wr_cycles", 64'(wr_count), tbl[t].is_wr ? 64'd8 : 64'd0);
            if (maddr_hist.size() > 9) begin
                chk("addr_first", 64'(maddr_hist[1]), 64'(tbl[t].a_first));
                chk("addr_last", 64'(maddr_hist[8]), 64'(tbl[t].a_last));
                if (tbl[t].is_wr) begin
                    chk("mem_word0", 64'(mem[tbl[t].a_first]), 64'(tbl[t].w0));
                    chk("mem_word7", 64'(mem[tbl[t].a_last]), 64'(tbl[t].w7));
                end else begin
                    chk("rdata_word0", 64'(rdata_hist[2]), 64'(tbl[t].w0));
                    chk("rdata_word7", 64'(rdata_hist[9]), 64'(tbl[t].w7));
                end
            end
        end

        // Simultaneous requests after reset: requester 0 first, 1 right after one IDLE cycle.
        do_reset(); clear_logs();
        push_job(0, 1'b0, 11'h000, 8'h00, 0);
        push_job(1, 1'b0, 11'h010, 8'h00, 0);
        drive();
        n = 0;
        while (done_log.size() < 2 && n < 60) begin step(); n++; end
        chk("pair_count", 64'(done_log.size()), 64'd2);
        if (done_log.size() >= 2) begin
            chk("pair_first", 64'(done_log[0]), 64'd0);
            chk("pair_second", 64'(done_log[1]), 64'd1);
            chk("pair_gap", 64'(done_cyc_log[1] - done_cyc_log[0]), 64'd11);
        end

        // Continuous re-requests: strict alternation with a single IDLE cycle between transfers.
        do_reset(); clear_logs();
        for (int i = 0; i < 2; i++) begin
            push_job(0, 1'b0, 11'h020, 8'h00, 0);
            push_job(1, 1'b0, 11'h030, 8'h00, 0);
        end
        drive();
        n = 0;
        while (done_log.size() < 4 && n < 80) begin step(); n++; end
        chk("rr_count", 64'(done_log.size()), 64'd4);
        if (done_log.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                chk("rr_order", 64'(done_log[i]), 64'(i % 2));
                if (i > 0) chk("rr_gap", 64'(done_cyc_log[i] - done_cyc_log[i-1]), 64'd11);
            end

        // Reset after the third write beat: no rollback, no further writes.
        preload(); do_reset(); clear_logs();
        push_job(1, 1'b1, 11'h010, 8'hB0, 0);
        drive();
        n = 0;
        while (bc[1] < 3 && n < 20) begin step(); n++; end
        chk("beats_before_rst", 64'(bc[1]), 64'd3);
        rst = 1'b1;
        #1;
        chk("rst_outs_a", 64'({beat, done, mem_wr_req, mem_addr}), 64'd0);
        chk("rst_outs_b", 64'({rdata, mem_wr_data}), 64'd0);
        clear_state();
        repeat (2) step();
        rst = 1'b0;
        chk("rst_word10", 64'(mem[16]), 64'hB0);
        chk("rst_word11", 64'(mem[17]), 64'hB1);
        chk("rst_word12", 64'(mem[18]), 64'hB2);
        chk("rst_word13", 64'(mem[19]), 64'hA2);

        // Random traffic from both requesters.
        do_reset(); clear_logs();
        for (int c = 0; c < 400; c++) begin
            if (jq0.size() < 2 && $urandom_range(0, 5) == 0)
                push_job(0, 1'($urandom_range(0, 1)), AW'($urandom), 8'h00, 1);
            if (jq1.size() < 2 && $urandom_range(0, 5) == 0)
                push_job(1, 1'($urandom_range(0, 1)), AW'($urandom), 8'h00, 1);
            drive();
            step();
        end
        n = 0;
        while ((jq0.size() + jq1.size()) > 0 && n < 200) begin step(); n++; end
        chk("drained", 64'(jq0.size() + jq1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_line_arbiter.md
MEM_LINE_ARBITER -- requirements
Module: mem_line_arbiter

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 11, meaning the word-address width of the backing memory.
REQ-002 SHALL have parameter LINE_LEN, default 3, meaning log2 of words per line; N = 2^LINE_LEN (default 8).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req  input  2  per-requester line-transfer request; held high until done.
REQ-006 we  input  2  per-requester direction: 1 = line write, 0 = line read.
REQ-007 addr  input  2*ADDR_LEN  requester i line base at [i*ADDR_LEN +: ADDR_LEN]; low LINE_LEN bits ignored.
REQ-008 wdata  input  64  requester i write beat at [i*32 +: 32].
REQ-009 beat  output  2  one-hot strobe to the granted requester, one strobe per transferred word.
REQ-010 rdata  output  32  read beat data; valid only while beat is high on a read.
REQ-011 done  output  2  one-cycle completion pulse to the granted requester.
REQ-012 mem_addr  output  ADDR_LEN  word address to the single-port memory.
REQ-013 mem_wr_req  output  1  memory write enable.
REQ-014 mem_wr_data  output  32  memory write data.
REQ-015 mem_rd_data  input  32  memory read data; registered one cycle after mem_addr.

Function
REQ-016 SHALL implement an FSM with states IDLE, READ, WRITE and DONE, plus a (LINE_LEN+1)-bit beat counter cnt.
REQ-017 In IDLE with any req high, SHALL grant one requester at the clock edge, latch base = addr[i] with the low LINE_LEN bits cleared, latch we[i], clear cnt, and enter READ or WRITE.
REQ-018 Arbitration SHALL be round-robin: a priority pointer names the preferred requester and flips to the other requester after each DONE.
REQ-019 A lone requester SHALL be granted regardless of the pointer.
REQ-020 Requests SHALL be sampled only in IDLE; req changes during READ, WRITE or DONE have no effect.
REQ-021 WRITE SHALL last N cycles (cnt 0..N-1). Each cycle: mem_addr = base | cnt, mem_wr_req = 1, mem_wr_data = wdata[g], beat[g] = 1. After cnt = N-1 the FSM goes to DONE.
REQ-022 READ SHALL last N+1 cycles (cnt 0..N).
- For cnt < N: mem_addr = base | cnt.
- For cnt >= 1: beat[g] = 1 and rdata = mem_rd_data (word cnt-1).
- After cnt = N the FSM goes to DONE.
REQ-023 DONE SHALL last one cycle with done[g] = 1, then return to IDLE.
REQ-024 The granted requester SHALL deassert req on the edge after seeing done, so a single request is never served twice.
REQ-025 The word offset SHALL wrap within the line; the counter never carries into the base (line at 0x7F8 covers 0x7F8..0x7FF).
REQ-026 Latency: with req first sampled at cycle 0 and default N = 8:
- Read: beats in cycles 2..9, done in cycle 10.
- Write: beats in cycles 1..8, done in cycle 9.
REQ-027 Outside READ/WRITE, mem_addr, mem_wr_data, rdata, beat and done SHALL be 0, and mem_wr_req SHALL be 0.

Reset
REQ-028 rst SHALL immediately force IDLE, cnt = 0, priority pointer = requester 0, and all outputs to 0, including mid-transfer.
REQ-029 Reset during WRITE SHALL leave the memory words already written unchanged; there is no rollback and no further writes occur.

Verification (memory preloaded: word 0..7 = 0x61,0xE6,0x60,0x54,0x72,0xE2,0xC3,0x46; word 19 = 0xA2)
REQ-030 After reset, req0 read addr 0x005 -> rdata 0x61,0xE6,0x60,0x54,0x72,0xE2,0xC3,0x46 on cycles 2..9, done[0] on cycle 10.
REQ-031 req0 and req1 raised together after reset -> requester 0 is served first, then requester 1 starting the cycle after done[0].
REQ-032 req1 write base 0x010, data 0xA0..0xA7, then req1 read 0x010 -> readback 0xA0..0xA7; mem_wr_req high for exactly 8 cycles.
REQ-033 Both requesters re-request continuously for 4 transfers -> grant order 0,1,0,1 with no idle gaps beyond one IDLE cycle per transfer.
REQ-034 rst asserted after the 3rd write beat at base 0x010 -> words 0x10..0x12 hold new data, word 0x13 = 0xA2, all outputs 0 within the reset cycle.
REQ-035 req0 read base 0x7FB -> mem_addr sequence 0x7F8..0x7FF with no wrap to 0x000.
